multicycle_ctrl: RTL and testbench

//  Multicycle RV32I-subset control FSM; drives ALUctrl and consumes the ALU EQ flag.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_alu_decoder.sv | 27 ++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV32I control path
//   alu_ctrl_t   ALU operation codes driven on ALUctrl
//   state_t      controller FSM states
//   OP_*         opcode values recognised by DECODE
//   SRCA_*/SRCB_*/RES_*/IMM_*/ALUOP_*  mux-select and ALU-op encodings
package ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps ALU-op class and instruction function fields to ALUctrl
//   alu_op    in  2  00 force ADD, 01 force SUB, 10 decode funct fields
//   funct3    in  3  instruction funct3
//   funct7b5  in  1  instruction bit 30
//   op5       in  1  opcode bit 5 (1 = R-type, 0 = I-type)
//   alu_ctrl  out 3  ALU operation
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctrl_t  alu_ctrl
);

    // Bit 30 only means SUB for R-type; for addi it is part of the immediate.
    always_comb begin
        alu_ctrl = alu_op == ALUOP_ADD ? ALU_ADD :
                   alu_op == ALUOP_SUB ? ALU_SUB :
                   funct3 == 3'b000    ? ((op5 && funct7b5) ? ALU_SUB : ALU_ADD) :
                   funct3 == 3'b010    ? ALU_SLT :
                   funct3 == 3'b110    ? ALU_OR  :
                   funct3 == 3'b111    ? ALU_AND : ALU_ADD;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I-subset control FSM with memory req/ready handshake
//   clk, rst_n (sync, active-low)        clock and reset
//   instr[31:0], EQ, mem_ready           inputs from IR, ALU zero flag, memory
//   mem_req, mem_we, adr_src             memory request / direction / address select
//   ir_write, pc_write, reg_write        architectural state write enables
//   alu_src_a, alu_src_b, result_src,
//   imm_src, ALUctrl                     datapath mux selects and ALU operation
//   timeout                              sticky: a request waited MEM_TIMEOUT cycles
//   illegal                              sticky: unknown opcode (CTRL_ILLEGAL_TRAP_EN only)
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes trap instead of acting as NOP)
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [2:0]  ALUctrl,
    output logic        timeout,
    output logic        illegal
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t         state, next;
    logic [1:0]     alu_op;
    alu_ctrl_t      alu_ctrl;
    logic [CW-1:0]  cnt;
    logic           timeout_q;
    logic [6:0]     opcode;
    logic           unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (instr[14:12]),
        .funct7b5 (instr[30]),
        .op5      (instr[5]),
        .alu_ctrl (alu_ctrl)
    );

    assign ALUctrl = alu_ctrl;
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    // Outputs are qualified by rst_n so that every strobe is low while reset is held,
    // which also drops an in-flight request without any partial write.
    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUREG;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALUOUT;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    next       = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Target pre-compute; JAL needs the J immediate for its jump target.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = opcode == OP_JAL ? IMM_J : IMM_B;
                    case (opcode)
                        OP_LOAD, OP_STORE: next = S_MEMADR;
                        OP_R:              next = S_EXEC_R;
                        OP_I:              next = S_EXEC_I;
                        OP_BR:             next = S_BRANCH;
                        OP_JAL:            next = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           next = S_TRAP;
`else
                        default:           next = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = opcode == OP_STORE ? IMM_S : IMM_I;
                    next      = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    next    = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    next    = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                    next       = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                    next      = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                    next      = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    next      = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_write  = instr[14:12] == 3'b000 ? EQ :
                                instr[14:12] == 3'b001 ? !EQ : 1'b0;
                    next      = S_FETCH;
                end
                S_JAL: begin
                    pc_write  = 1'b1;
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    next      = S_ALUWB;
                end
                S_TRAP:  next = S_TRAP;
                default: next = S_FETCH;
            endcase
        end
    end

    // Counts cycles a request has waited; any cycle without a pending request clears it,
    // so each new request starts from zero. Saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else if (mem_req && !mem_ready) begin
            if (cnt != CW'(MEM_TIMEOUT)) cnt <= cnt + 1'b1;
            if (cnt == CW'(MEM_TIMEOUT - 1)) timeout_q <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (!rst_n)                                illegal_q <= 1'b0;
        else if (state == S_DECODE && next == S_TRAP) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  ALUctrl;
    logic        timeout, illegal;
    logic [16:0] outs;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .ALUctrl(ALUctrl), .timeout(timeout), .illegal(illegal)
    );

    // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, srcA, srcB, result, imm, ALUctrl}
    assign outs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, imm_src, ALUctrl};

    localparam logic [16:0] E_IDLE   = '0;
    localparam logic [16:0] E_FW     = {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000};
    localparam logic [16:0] E_FR     = {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000};
    localparam logic [16:0] E_DEC    = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000};
    localparam logic [16:0] E_DECJ   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b11, 3'b000};
    localparam logic [16:0] E_XR_ADD = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_XR_SUB = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001};
    localparam logic [16:0] E_XR_OR  = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b011};
    localparam logic [16:0] E_XR_AND = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010};
    localparam logic [16:0] E_XI_SLT = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b101};
    localparam logic [16:0] E_XI_ADD = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_AWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_BR_T   = {6'b000010, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001};
    localparam logic [16:0] E_BR_N   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001};
    localparam logic [16:0] E_MA_L   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MA_S   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000};
    localparam logic [16:0] E_MR     = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MW     = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000};
    localparam logic [16:0] E_JAL    = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction through FETCH (ready one cycle late) and lands in DECODE.
    task automatic fetch_decode(input logic [31:0] ins, input logic [16:0] dec_exp, input string name);
        instr = ins; mem_ready = 1'b0; #1;
        total++; if (outs !== E_FW) $display("FAIL %s fetch_wait got %h exp %h", name, outs, E_FW); else passed++;
        tick; mem_ready = 1'b1; #1;
        total++; if (outs !== E_FR) $display("FAIL %s fetch_ready got %h exp %h", name, outs, E_FR); else passed++;
        tick; mem_ready = 1'b0; #1;
        total++; if (outs !== dec_exp) $display("FAIL %s decode got %h exp %h", name, outs, dec_exp); else passed++;
    endtask

    task automatic run_alu(input logic [31:0] ins, input logic [16:0] exec_exp, input string name);
        fetch_decode(ins, E_DEC, name);
        tick; mem_ready = 1'b1; #1;
        total++; if (outs !== exec_exp) $display("FAIL %s exec got %h exp %h", name, outs, exec_exp); else passed++;
        tick; #1;
        total++; if (outs !== E_AWB) $display("FAIL %s aluwb got %h exp %h", name, outs, E_AWB); else passed++;
        tick; mem_ready = 1'b0; #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1;
        tick; tick; #1;
        total++; if (outs !== E_IDLE) $display("FAIL reset_outs got %h exp %h", outs, E_IDLE); else passed++;
        total++; if ({timeout, illegal} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {timeout, illegal}); else passed++;
        rst_n = 1'b1; mem_ready = 1'b0; #1;
    endtask

    task automatic test_alu;
        run_alu(32'h002081B3, E_XR_ADD, "add");
        run_alu(32'h402081B3, E_XR_SUB, "sub");
        run_alu(32'h0020E1B3, E_XR_OR,  "or");
        run_alu(32'h0020F1B3, E_XR_AND, "and");
        run_alu(32'h0050A193, E_XI_SLT, "slti");
        run_alu(32'h40008193, E_XI_ADD, "addi_b30");
    endtask

    task automatic test_branch;
        fetch_decode(32'h00208063, E_DEC, "beq");
        tick; EQ = 1'b1; #1;
        total++; if (outs !== E_BR_T) $display("FAIL beq_eq1 got %h exp %h", outs, E_BR_T); else passed++;
        EQ = 1'b0; #1;
        total++; if (outs !== E_BR_N) $display("FAIL beq_eq0 got %h exp %h", outs, E_BR_N); else passed++;
        tick; #1;
        total++; if (outs !== E_FW) $display("FAIL beq_next got %h exp %h", outs, E_FW); else passed++;
        fetch_decode(32'h00209063, E_DEC, "bne");
        tick; EQ = 1'b0; #1;
        total++; if (outs !== E_BR_T) $display("FAIL bne_eq0 got %h exp %h", outs, E_BR_T); else passed++;
        EQ = 1'b1; #1;
        total++; if (outs !== E_BR_N) $display("FAIL bne_eq1 got %h exp %h", outs, E_BR_N); else passed++;
        tick; #1;
        total++; if (outs !== E_FW) $display("FAIL bne_next got %h exp %h", outs, E_FW); else passed++;
        fetch_decode(32'h0020C063, E_DEC, "blt");
        tick; EQ = 1'b1; #1;
        total++; if (outs !== E_BR_N) $display("FAIL blt_eq1 got %h exp %h", outs, E_BR_N); else passed++;
        tick; EQ = 1'b0; #1;
    endtask

    task automatic test_load;
        fetch_decode(32'h0000A183, E_DEC, "lw");
        tick; #1;
        total++; if (outs !== E_MA_L) $display("FAIL lw_memadr got %h exp %h", outs, E_MA_L); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick; mem_ready = (i == 2); #1;
            total++; if (outs !== E_MR) $display("FAIL lw_memread%0d got %h exp %h", i, outs, E_MR); else passed++;
        end
        tick; mem_ready = 1'b0; #1;
        total++; if (outs !== E_MWB) $display("FAIL lw_memwb got %h exp %h", outs, E_MWB); else passed++;
        tick; #1;
        total++; if (outs !== E_FW) $display("FAIL lw_next got %h exp %h", outs, E_FW); else passed++;
    endtask

    task automatic test_jal;
        fetch_decode(32'h000000EF, E_DECJ, "jal");
        tick; mem_ready = 1'b1; #1;
        total++; if (outs !== E_JAL) $display("FAIL jal_exec got %h exp %h", outs, E_JAL); else passed++;
        tick; #1;
        total++; if (outs !== E_AWB) $display("FAIL jal_aluwb got %h exp %h", outs, E_AWB); else passed++;
        tick; mem_ready = 1'b0; #1;
        total++; if (outs !== E_FW) $display("FAIL jal_next got %h exp %h", outs, E_FW); else passed++;
    endtask

    task automatic test_timeout;
        fetch_decode(32'h0020A023, E_DEC, "sw");
        tick; #1;
        total++; if (outs !== E_MA_S) $display("FAIL sw_memadr got %h exp %h", outs, E_MA_S); else passed++;
        tick; #1;
        repeat (15) tick;
        total++; if ({timeout, outs} !== {1'b0, E_MW}) $display("FAIL sw_wait15 got %b/%h exp 0/%h", timeout, outs, E_MW); else passed++;
        tick;
        total++; if ({timeout, outs} !== {1'b1, E_MW}) $display("FAIL sw_wait16 got %b/%h exp 1/%h", timeout, outs, E_MW); else passed++;
        repeat (20) tick;
        total++; if ({timeout, outs} !== {1'b1, E_MW}) $display("FAIL sw_wait36 got %b/%h exp 1/%h", timeout, outs, E_MW); else passed++;
        mem_ready = 1'b1; tick; mem_ready = 1'b0; #1;
        total++; if ({timeout, outs} !== {1'b1, E_FW}) $display("FAIL sw_done got %b/%h exp 1/%h", timeout, outs, E_FW); else passed++;
    endtask

    task automatic test_reset_mid;
        fetch_decode(32'h0000A183, E_DEC, "lw_rst");
        tick; tick; #1;
        total++; if (outs !== E_MR) $display("FAIL rst_memread got %h exp %h", outs, E_MR); else passed++;
        rst_n = 1'b0; #1;
        total++; if (outs !== E_IDLE) $display("FAIL rst_low_outs got %h exp %h", outs, E_IDLE); else passed++;
        tick; mem_ready = 1'b1; #1;
        total++; if ({timeout, outs} !== {1'b0, E_IDLE}) $display("FAIL rst_edge got %b/%h exp 0/%h", timeout, outs, E_IDLE); else passed++;
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        total++; if (outs !== E_FW) $display("FAIL rst_fetch got %h exp %h", outs, E_FW); else passed++;
    endtask

    task automatic test_illegal;
        fetch_decode(32'h0000007F, E_DEC, "illegal");
        tick; #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        total++; if ({illegal, outs} !== {1'b1, E_IDLE}) $display("FAIL trap_enter got %b/%h exp 1/%h", illegal, outs, E_IDLE); else passed++;
        mem_ready = 1'b1; repeat (5) tick; mem_ready = 1'b0;
        total++; if ({illegal, outs} !== {1'b1, E_IDLE}) $display("FAIL trap_stuck got %b/%h exp 1/%h", illegal, outs, E_IDLE); else passed++;
        rst_n = 1'b0; tick; rst_n = 1'b1; #1;
        total++; if ({illegal, outs} !== {1'b0, E_FW}) $display("FAIL trap_reset got %b/%h exp 0/%h", illegal, outs, E_FW); else passed++;
`else
        total++; if ({illegal, outs} !== {1'b0, E_FW}) $display("FAIL nop_fetch got %b/%h exp 0/%h", illegal, outs, E_FW); else passed++;
`endif
    endtask

    initial begin
        test_reset;
        test_alu;
        test_branch;
        test_load;
        test_jal;
        test_timeout;
        test_reset_mid;
        test_illegal;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
